// File: rtl/pulse_width_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_generator_if
// Description : Control and status bundle of the pulse width generator.
//               master = controller side (drives requests and operands),
//               slave  = generator side (drives pulse and status).
//               Signals:
//                 start, stop            one-cycle requests
//                 width_us, period_us    pulse high time / period in us
//                 num_pulses             train length, 0 = continuous
//                 pulse_out              generated pulse
//                 ready, busy            idle / running indication
//                 done, err              end-of-train / rejected-start strobes
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_width_generator_if #(
    parameter int DATAWIDTH = 30
);
    logic                 start;
    logic                 stop;
    logic [DATAWIDTH-1:0] width_us;
    logic [DATAWIDTH-1:0] period_us;
    logic [15:0]          num_pulses;
    logic                 pulse_out;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, stop, width_us, period_us, num_pulses,
        input  pulse_out, ready, busy, done, err
    );

    modport slave (
        input  start, stop, width_us, period_us, num_pulses,
        output pulse_out, ready, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/pulse_width_generator.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_generator
// Description : Generates a train of rectangular pulses whose width and period
//               are programmed in microseconds. One microsecond is exactly
//               CLK_FREQ_MHZ cycles of sys_clk, timed by a free prescaler.
//               Ports:
//                 sys_clk   system clock, rising edge
//                 sys_rst   synchronous active-high reset
//                 bus       pulse_width_generator_if.slave (requests,
//                           operands, pulse output and status strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_generator #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int DATAWIDTH    = 30
) (
    input  wire logic                      sys_clk,
    input  wire logic                      sys_rst,
    pulse_width_generator_if.slave         bus
);

    localparam int c_PRESC_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLK_FREQ_MHZ - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [DATAWIDTH-1:0] r_us_cnt;
    logic [15:0]          r_pulse_cnt;
    logic                 r_stop_pend;
    logic [DATAWIDTH-1:0] r_width;
    logic [DATAWIDTH-1:0] r_low_len;
    logic [15:0]          r_num;

    logic                 r_pulse_out;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_pulse_nxt;
    logic                 w_ready_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;

    logic                 w_us_tick;
    logic                 w_legal;
    logic                 w_accept;
    logic [DATAWIDTH-1:0] w_phase_len;
    logic                 w_phase_end;
    logic                 w_last;

    assign w_us_tick   = (r_presc == c_PRESC_LAST);
    assign w_legal     = (bus.width_us != '0) && (bus.period_us > bus.width_us);
    assign w_accept    = (r_state == c_ST_IDLE) && bus.start && w_legal;
    assign w_phase_len = (r_state == c_ST_HIGH) ? r_width : r_low_len;
    // Phase lengths are always >= 1 us, so the minus-one cannot wrap.
    assign w_phase_end = (r_state != c_ST_IDLE) && w_us_tick &&
                         (r_us_cnt == w_phase_len - DATAWIDTH'(1));
    // A stop arriving in the very last cycle of the low phase still ends the
    // train at this boundary, so it is ORed in alongside the pending flag.
    assign w_last      = r_stop_pend || bus.stop ||
                         ((r_num != '0) && (r_pulse_cnt + 16'd1 == r_num));

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)    w_state_nxt = c_ST_HIGH;
            c_ST_HIGH: if (w_phase_end) w_state_nxt = c_ST_LOW;
            c_ST_LOW:  if (w_phase_end) w_state_nxt = w_last ? c_ST_IDLE : c_ST_HIGH;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic: next values, registered below so every output is a flop
    always_comb begin
        w_pulse_nxt = (w_state_nxt == c_ST_HIGH);
        w_ready_nxt = (w_state_nxt == c_ST_IDLE);
        w_done_nxt  = (r_state == c_ST_LOW) && w_phase_end && w_last;
        w_err_nxt   = (r_state == c_ST_IDLE) && bus.start && !w_legal;
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_presc     <= '0;
            r_us_cnt    <= '0;
            r_pulse_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_width     <= '0;
            r_low_len   <= '0;
            r_num       <= '0;
            r_pulse_out <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pulse_out <= w_pulse_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= ~w_ready_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;

            if (r_state == c_ST_IDLE) begin
                r_presc  <= '0;
                r_us_cnt <= '0;
                if (w_accept) begin
                    r_width     <= bus.width_us;
                    r_low_len   <= bus.period_us - bus.width_us;
                    r_num       <= bus.num_pulses;
                    r_pulse_cnt <= '0;
                    r_stop_pend <= 1'b0;
                end
            end else begin
                if (bus.stop) begin
                    r_stop_pend <= 1'b1;
                end
                // Prescaler wraps on its terminal count, which coincides with
                // every phase end, so each phase starts on a fresh microsecond.
                r_presc <= w_us_tick ? '0 : r_presc + c_PRESC_W'(1);
                if (w_phase_end) begin
                    r_us_cnt <= '0;
                end else if (w_us_tick) begin
                    r_us_cnt <= r_us_cnt + DATAWIDTH'(1);
                end
                if (w_phase_end && (r_state == c_ST_LOW)) begin
                    r_pulse_cnt <= r_pulse_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.pulse_out = r_pulse_out;
    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_width_generator
// Description : Self-checking bench for pulse_width_generator with F = 4.
//               Stimulus pushes expected pulse edges / done / err events
//               (kind + cycle) into a queue; a monitor pops and compares them
//               as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_width_generator;

    localparam int F  = 4;
    localparam int DW = 30;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    ev_t  exp_q[$];
    logic prev_pulse = 1'b0;

    pulse_width_generator_if #(.DATAWIDTH(DW)) bus ();

    pulse_width_generator #(
        .CLK_FREQ_MHZ (F),
        .DATAWIDTH    (DW)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    endtask

    task automatic push_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Expected edges of npulse pulses plus the closing done strobe.
    task automatic push_train(input int t, input int w, input int p, input int npulse);
        for (int k = 0; k < npulse; k++) begin
            push_ev(t + 1 + k * p * F, K_RISE);
            push_ev(t + 1 + k * p * F + w * F, K_FALL);
        end
        push_ev(t + npulse * p * F + 1, K_DONE);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc) n_pass++;
            else $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                          kind, cyc, e.kind, e.cyc);
        end
    endtask

    // Monitor
    always @(negedge sys_clk) begin
        if (bus.pulse_out === 1'b1 && prev_pulse === 1'b0) handle(K_RISE);
        if (bus.pulse_out === 1'b0 && prev_pulse === 1'b1) handle(K_FALL);
        if (bus.done === 1'b1) handle(K_DONE);
        if (bus.err  === 1'b1) handle(K_ERR);
        prev_pulse = bus.pulse_out;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drive_start(input int w, input int p, input int n);
        bus.width_us   = DW'(w);
        bus.period_us  = DW'(p);
        bus.num_pulses = 16'(n);
        bus.start      = 1'b1;
    endtask

    initial begin
        int t;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.width_us   = '0;
        bus.period_us  = '0;
        bus.num_pulses = '0;

        // Reset state
        tick(); tick(); tick();
        @(negedge sys_clk);
        chk("rst_pulse_out", bus.pulse_out, 1'b0);
        chk("rst_ready",     bus.ready,     1'b1);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_err",       bus.err,       1'b0);
        tick();
        sys_rst = 1'b0;
        go_to(10);

        // Finite train W=2 P=5 N=3
        t = cyc;
        drive_start(2, 5, 3);
        push_train(t, 2, 5, 3);
        tick();
        bus.start = 1'b0;
        go_to(t + 8);  @(negedge sys_clk); chk("train_high_last", bus.pulse_out, 1'b1);
        go_to(t + 9);  @(negedge sys_clk); chk("train_low_first", bus.pulse_out, 1'b0);
        go_to(t + 60); @(negedge sys_clk); chk("train_busy_end",  bus.busy,      1'b1);
        go_to(t + 61); @(negedge sys_clk); chk("train_ready_done", bus.ready,    1'b1);
        go_to(t + 66);

        // Continuous train W=1 P=3 stopped during pulse 2
        t = cyc;
        drive_start(1, 3, 0);
        push_train(t, 1, 3, 3);
        tick();
        bus.start = 1'b0;
        go_to(t + 30);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        go_to(t + 36); @(negedge sys_clk);
        chk("stop_low_tail", bus.pulse_out, 1'b0);
        chk("stop_busy_tail", bus.busy, 1'b1);
        go_to(t + 37); @(negedge sys_clk); chk("stop_ready_done", bus.ready, 1'b1);
        go_to(t + 55);

        // Illegal parameters: W=0 and W=P
        t = cyc;
        drive_start(0, 5, 1);
        push_ev(t + 1, K_ERR);
        tick();
        bus.start = 1'b0;
        @(negedge sys_clk);
        chk("ill0_ready", bus.ready, 1'b1);
        chk("ill0_pulse", bus.pulse_out, 1'b0);
        go_to(t + 4);
        t = cyc;
        drive_start(5, 5, 1);
        push_ev(t + 1, K_ERR);
        tick();
        bus.start = 1'b0;
        @(negedge sys_clk);
        chk("ill5_ready", bus.ready, 1'b1);
        tick();
        @(negedge sys_clk);
        chk("ill5_pulse", bus.pulse_out, 1'b0);
        go_to(t + 6);

        // Start held high while busy: operands must not be re-sampled
        t = cyc;
        drive_start(3, 9, 1);
        push_train(t, 3, 9, 1);
        tick();
        drive_start(1, 2, 5);
        go_to(t + 37);
        bus.start = 1'b0;
        go_to(t + 42);

        // Reset in the middle of a high phase, then a fresh train
        t = cyc;
        drive_start(3, 9, 0);
        push_ev(t + 1, K_RISE);
        push_ev(t + 6, K_FALL);
        tick();
        bus.start = 1'b0;
        go_to(t + 5);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("mrst_pulse", bus.pulse_out, 1'b0);
        chk("mrst_ready", bus.ready,     1'b1);
        chk("mrst_done",  bus.done,      1'b0);
        chk("mrst_busy",  bus.busy,      1'b0);
        go_to(t + 7);
        drive_start(1, 2, 1);
        push_train(t + 7, 1, 2, 1);
        tick();
        bus.start = 1'b0;
        go_to(t + 11); @(negedge sys_clk); chk("mrst_high_last", bus.pulse_out, 1'b1);
        go_to(t + 12); @(negedge sys_clk); chk("mrst_low_first", bus.pulse_out, 1'b0);
        go_to(t + 20);

        // Back-to-back trains: second start issued in the done cycle
        t = cyc;
        drive_start(1, 2, 1);
        push_train(t, 1, 2, 1);
        tick();
        bus.start = 1'b0;
        go_to(t + 9);
        drive_start(1, 2, 1);
        push_train(t + 9, 1, 2, 1);
        tick();
        bus.start = 1'b0;
        go_to(t + 25);

        @(negedge sys_clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_width_generator.md
# pulse_width_generator

Generates a train of rectangular pulses with pulse width and period programmed in microseconds. Each µs is timed as exactly CLK_FREQ_MHZ cycles of the system clock. It is the stimulus end of the pulse-width measurement path. Its output drives the measured-pulse input, either looped back on the board or in simulation, so the measurement chain can be checked against a known width.

## Interface
- CLK_FREQ_MHZ, 50: system clock frequency in MHz, which is the number of cycles per µs; must be ≥ 1.
- DATAWIDTH, 30: width of the µs operands and µs counters.
- sys_clk  input  1  system clock; every register is clocked on its rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only while ready=1.
- stop  input  1  one-cycle request to end a running train at the next period boundary.
- width_us  input  DATAWIDTH  high time in µs; sampled on an accepted start.
- period_us  input  DATAWIDTH  period in µs; sampled on an accepted start.
- num_pulses  input  16  number of pulses to generate; 0 means continuous until stop; sampled on an accepted start.
- pulse_out  output  1  generated pulse, driven directly from a register.
- ready  output  1  high in IDLE; start is accepted only when high.
- busy  output  1  equal to the inverse of ready.
- done  output  1  one-cycle strobe when a train ends, whether normally or by stop.
- err  output  1  one-cycle strobe when a start is rejected for illegal parameters.

## Operation
- States: IDLE, HIGH, LOW.
- Internal counters:
  - prescaler: $clog2(CLK_FREQ_MHZ) bits, minimum 1, counting 0..CLK_FREQ_MHZ-1; it emits us_tick on its terminal count.
  - us_cnt: DATAWIDTH bits.
  - pulse_cnt: 16 bits.
  - stop_pend: 1 bit.
- IDLE behaviour:
  - pulse_out=0, ready=1, prescaler and us_cnt held at 0.
  - On start with width_us ≠ 0 and period_us > width_us: latch all three operands, clear stop_pend, go to HIGH.
  - Otherwise, on start: pulse err for one cycle and stay in IDLE.
- HIGH:
  - pulse_out=1.
  - us_cnt increments on each us_tick.
  - When us_tick occurs with us_cnt = width-1: go to LOW and restart the prescaler.
- LOW:
  - pulse_out=0.
  - Counts period-width µs in the same way.
  - At the end of the LOW phase, pulse_cnt increments.
  - If stop_pend=1, or (num≠0 and pulse_cnt+1 = num): go to IDLE and assert done.
  - Otherwise go to HIGH.
- stop handling:
  - stop while in HIGH or LOW sets stop_pend.
  - The current pulse always completes, including its full low phase. Pulses are never truncated, so the measurement side never sees a short pulse.
  - stop in IDLE is ignored.
- start while busy is ignored; operands are not re-sampled.
- Arithmetic:
  - Compares are unsigned at DATAWIDTH.
  - period-width is computed once at latch time into a DATAWIDTH-bit register; it cannot underflow because the legality check has already passed.
  - No multiplier is used; µs timing comes only from the prescaler.
- Simultaneous start and stop in IDLE: the start is accepted and the stop is ignored.
- Reset: if sys_rst is high at a clock edge, then after that edge pulse_out=0, done=0, err=0, ready=1, busy=0, the state is IDLE and all counters are 0. This applies mid-pulse as well.

## Timing
- Let F = CLK_FREQ_MHZ, W = width_us, P = period_us, N = num_pulses.
- Start is accepted in cycle T.
- pulse_out is 1 in cycles T+1 … T+W·F and 0 in cycles T+W·F+1 … T+P·F.
- Pulse k (k = 0, 1, …) rises at cycle T+1+k·P·F.
- Normal end: done=1 and ready=1 in cycle T+N·P·F+1. A new start is accepted in that same cycle, so trains can run back-to-back.
- Stop: if stop is accepted during pulse k, done=1 in cycle T+(k+1)·P·F+1.
- err asserts in cycle T+1 after a rejected start in cycle T; ready stays 1 throughout.
- Each period is exactly P·F cycles, with no extra cycles between periods.
- All outputs are registered.

## Test plan
- F=4, W=2, P=5, N=3, start at T → pulse_out high T+1..T+8, low T+9..T+20; next rises at T+21 and T+41; done only at T+61; exactly 3 rising edges.
- F=4, W=1, P=3, N=0, stop at T+30 → pulse 2 completes; done at T+37, pulse_out=0 from T+29; no 4th rising edge.
- Illegal parameters: W=0, P=5 → err one cycle, ready stays 1, pulse_out stays 0. W=5, P=5 → same response.
- Start pulsed every cycle while busy with W=3, P=9 → the waveform stays identical to the first accepted start: high 3·F cycles, period 9·F cycles.
- sys_rst high at T+5 in the middle of a HIGH phase → at T+6, pulse_out=0, ready=1, done=0; a new start with W=1, P=2 at T+7 gives high cycles T+8..T+11 with F=4.
- Loopback with F=50, W=37, P=100, N=1 into the measurement block → reported width 37 µs, within ±1 µs.
